// File: rtl/ahb_slave_mem.sv
// AHB slave responder backed by a byte-addressable memory covering [LOW_ADDR, HIGH_ADDR].
// Legal transfers see WAIT_STATES stall cycles. Illegal transfers get a two-cycle ERROR response.
module ahb_slave_mem #(
    parameter int LOW_ADDR    = 0,
    parameter int HIGH_ADDR   = 31,
    parameter int WAIT_STATES = 0,
    parameter int DATA_WIDTH  = 32
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int DEPTH  = HIGH_ADDR - LOW_ADDR + 1;
    localparam int WORDS  = DEPTH / 4;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [32:0] LOW33  = 33'(LOW_ADDR);
    localparam logic [32:0] HIGH33 = 33'(HIGH_ADDR);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t              state, state_nx;
    logic [2:0]          cnt, cnt_nx;
    logic [31:0]         addr_q;
    logic                write_q;
    logic [1:0]          size_q;
    logic [3:0][7:0]     mem [WORDS];

    logic                capture, legal, aligned;
    logic [32:0]         last_byte;
    logic [3:0]          be;
    logic [31:0]         offset;
    logic [WIDX_W-1:0]   widx;
    logic                unused_ok;

    assign unused_ok = ^{HBURST, HTRANS[0], (DATA_WIDTH == 32)};

    // A new address phase is only accepted when no data phase is being stalled.
    assign capture = HSEL && HREADY &&
                     (state == S_IDLE || state == S_DONE || state == S_ERR2);

    assign last_byte = {1'b0, HADDR} + (33'd1 << HSIZE[1:0]) - 33'd1;

    always_comb begin
        aligned = 1'b1;
        if (HSIZE == 3'd1) aligned = !HADDR[0];
        if (HSIZE == 3'd2) aligned = (HADDR[1:0] == 2'b00);
    end

    assign legal = (HSIZE <= 3'd2) && aligned &&
                   ({1'b0, HADDR} >= LOW33) && ({1'b0, HADDR} <= HIGH33) &&
                   (last_byte <= HIGH33);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt == 3'd0) state_nx = S_DONE;
                else             cnt_nx   = cnt - 3'd1;
            end
            S_ERR1: state_nx = S_ERR2;
            default: begin
                state_nx = S_IDLE;
                if (capture && HTRANS[1]) begin
                    if (!legal) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = 3'(WAIT_STATES - 1);
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
        endcase
    end

    // Window is word aligned, so the word index and lane enables come straight from the address.
    assign offset = addr_q - 32'(LOW_ADDR);
    assign widx   = WIDX_W'(offset >> 2);

    always_comb begin
        be = 4'b0001;
        if (size_q == 2'd1) be = 4'b0011;
        if (size_q == 2'd2) be = 4'b1111;
        be = be << addr_q[1:0];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            for (int w = 0; w < WORDS; w++) mem[w] <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
            end
            if (state == S_DONE && write_q) begin
                for (int j = 0; j < 4; j++)
                    if (be[j]) mem[widx][j] <= HWDATA[8*j +: 8];
            end
        end
    end

    assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'd1 : 2'd0;

    always_comb begin
        HRDATA = 32'd0;
        if (state == S_DONE && !write_q) begin
            for (int j = 0; j < 4; j++)
                if (be[j]) HRDATA[8*j +: 8] = mem[widx][j];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 3 and 2 wait states) share one bus.
// A table of transfers feeds a scoreboard queue that a bus monitor checks at each data-phase completion.
module tb_ahb_slave_mem;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic              HRESET;
    logic [2:0]        hsel;
    logic [31:0]       HADDR, HWDATA;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE, HBURST;
    logic [2:0]        rdy;
    logic [2:0][1:0]   resp;
    logic [2:0][31:0]  rdata;
    logic              bus_ready;
    logic [1:0]        bus_resp;
    logic [31:0]       bus_rdata;

    assign bus_ready = &rdy;
    assign bus_resp  = resp[0] | resp[1] | resp[2];
    assign bus_rdata = rdata[0] | rdata[1] | rdata[2];

    ahb_slave_mem #(.LOW_ADDR(0), .HIGH_ADDR(31), .WAIT_STATES(0), .DATA_WIDTH(32)) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(bus_ready),
        .HREADYOUT(rdy[0]), .HRESP(resp[0]), .HRDATA(rdata[0]));
    ahb_slave_mem #(.LOW_ADDR(0), .HIGH_ADDR(31), .WAIT_STATES(3), .DATA_WIDTH(32)) u_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(bus_ready),
        .HREADYOUT(rdy[1]), .HRESP(resp[1]), .HRDATA(rdata[1]));
    ahb_slave_mem #(.LOW_ADDR(0), .HIGH_ADDR(31), .WAIT_STATES(2), .DATA_WIDTH(32)) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(bus_ready),
        .HREADYOUT(rdy[2]), .HRESP(resp[2]), .HRDATA(rdata[2]));

    typedef struct {
        int          s;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    localparam int WS [3] = '{0, 3, 2};

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_cmp = 0, n_fail = 0;
    int   drv_to = 0, drv_to_seen = 0;
    int   nwait = 0, nlowerr = 0;
    bit   dp_active = 0, cap_next = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus monitor: negedge samples outputs, posedge tracks captures and resets.
    always @(posedge HCLK or negedge HCLK) begin
        if (HCLK) begin
            if (HRESET) begin
                sbq.delete();
                dp_active = 0;
                cap_next  = 0;
            end else begin
                if (cap_next) begin
                    dp_active = 1;
                    nwait     = 0;
                    nlowerr   = 0;
                end
                cap_next = 0;
            end
        end else begin
            if (drv_to != drv_to_seen) begin
                chk("capture_timeout", drv_to, drv_to_seen);
                drv_to_seen = drv_to;
            end
            if (dp_active) begin
                if (!bus_ready) begin
                    nwait++;
                    if (bus_resp == 2'd1) nlowerr++;
                    if (nwait > 40) begin
                        chk("data_phase_timeout", nwait, 40);
                        dp_active = 0;
                        if (sbq.size() > 0) void'(sbq.pop_front());
                    end
                end else if (sbq.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                    dp_active = 0;
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("hresp", 32'(bus_resp), e.err ? 32'd1 : 32'd0);
                    chk("hrdata", bus_rdata, e.rdata);
                    chk("wait_cycles", nwait, e.waits);
                    chk("error_low_cycles", nlowerr, e.err ? 32'd1 : 32'd0);
                    dp_active = 0;
                end
            end else if (!HRESET) begin
                chk("idle_hreadyout", 32'(bus_ready), 32'd1);
                chk("idle_hresp", 32'(bus_resp), 32'd0);
                chk("idle_hrdata", bus_rdata, 32'd0);
            end
            cap_next = (|hsel) && bus_ready && !HRESET;
        end
    end

    task automatic add(input int s, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rd);
        vec_t v;
        v.s = s; v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
        v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rd;
        tbl.push_back(v);
    endtask

    // Drives one address phase; returns one cycle after the capturing edge with HWDATA set.
    task automatic xfer(input vec_t v);
        exp_t e;
        int   n;
        hsel   = 3'b000;
        if (v.sel) hsel[v.s] = 1'b1;
        HADDR  = v.addr;
        HTRANS = v.trans;
        HWRITE = v.wr;
        HSIZE  = v.size;
        HBURST = 3'd0;
        if (!v.sel) begin
            @(posedge HCLK); #1;
        end else begin
            n = 0;
            while (!bus_ready && n < 40) begin
                @(posedge HCLK); #1;
                n++;
            end
            if (!bus_ready) begin
                drv_to++;
            end else begin
                e.err   = v.err;
                e.waits = v.err ? 1 : (v.trans[1] ? WS[v.s] : 0);
                e.rdata = v.rdata;
                sbq.push_back(e);
                @(posedge HCLK); #1;
                HWDATA = v.wdata;
            end
        end
        hsel   = 3'b000;
        HTRANS = 2'd0;
    endtask

    localparam logic [1:0] IDL = 2'd0, BSY = 2'd1, NSQ = 2'd2;
    localparam logic [2:0] BY = 3'd0, HW = 3'd1, WD = 3'd2;

    initial begin
        vec_t v;
        int   n;
        add(0, 1, NSQ, 1, WD, 32'h08, 32'hDEADBEEF, 0, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h08, 32'h0,        0, 32'hDEADBEEF);
        add(0, 1, NSQ, 1, BY, 32'h09, 32'h00005A00, 0, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h08, 32'h0,        0, 32'hDEAD5AEF);
        add(0, 1, NSQ, 0, HW, 32'h0A, 32'h0,        0, 32'hDEAD0000);
        add(0, 1, NSQ, 0, WD, 32'h02, 32'h0,        1, 32'h0);
        add(0, 1, NSQ, 1, WD, 32'h20, 32'hFFFFFFFF, 1, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h00, 32'h0,        0, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h1C, 32'h0,        0, 32'h0);
        add(0, 1, BSY, 0, WD, 32'h08, 32'h0,        0, 32'h0);
        add(0, 1, IDL, 1, WD, 32'h08, 32'h12345678, 0, 32'h0);
        add(0, 0, NSQ, 1, WD, 32'h08, 32'h0,        0, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h08, 32'h0,        0, 32'hDEAD5AEF);
        add(0, 1, NSQ, 1, BY, 32'h1F, 32'h7E000000, 0, 32'h0);
        add(0, 1, NSQ, 0, WD, 32'h1C, 32'h0,        0, 32'h7E000000);
        add(0, 1, NSQ, 0, HW, 32'h1E, 32'h0,        0, 32'h7E000000);
        add(0, 1, NSQ, 0, 3'd3, 32'h00, 32'h0,      1, 32'h0);
        add(0, 1, NSQ, 0, HW, 32'h01, 32'h0,        1, 32'h0);
        add(0, 1, NSQ, 0, BY, 32'h0B, 32'h0,        0, 32'hDE000000);
        add(1, 1, NSQ, 1, WD, 32'h04, 32'h01020304, 0, 32'h0);
        add(1, 1, NSQ, 0, WD, 32'h04, 32'h0,        0, 32'h01020304);
        add(2, 1, NSQ, 1, WD, 32'h10, 32'h11223344, 0, 32'h0);
        add(2, 1, NSQ, 0, WD, 32'h10, 32'h0,        0, 32'h11223344);

        HRESET = 1'b1; hsel = 3'b000; HADDR = 32'h0; HTRANS = 2'd0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(posedge HCLK); #1;

        foreach (tbl[i]) xfer(tbl[i]);

        // Reset during the wait phase of a write must drop the write and clear memory.
        v = '{s: 2, sel: 1, trans: NSQ, wr: 1, size: WD, addr: 32'h10, wdata: 32'hAABBCCDD,
              err: 0, rdata: 32'h0};
        xfer(v);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        v = '{s: 2, sel: 1, trans: NSQ, wr: 0, size: WD, addr: 32'h10, wdata: 32'h0,
              err: 0, rdata: 32'h0};
        xfer(v);
        v = '{s: 0, sel: 1, trans: NSQ, wr: 0, size: WD, addr: 32'h08, wdata: 32'h0,
              err: 0, rdata: 32'h0};
        xfer(v);

        n = 0;
        while ((sbq.size() != 0 || dp_active) && n < 100) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n >= 100) drv_to++;
        repeat (3) @(posedge HCLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
